// File: rtl/nexys_starship_combo_entry_pkg.sv
// Shared constants for the starship combo-entry block: button FSM encodings,
// LFSR polynomial and seed, and the default debounce window.
`timescale 1ns/1ps
package nexys_starship_combo_entry_pkg;

  localparam logic [4:0] CE_INI  = 5'b00001;
  localparam logic [4:0] CE_WQ   = 5'b00010;
  localparam logic [4:0] CE_SCEN = 5'b00100;
  localparam logic [4:0] CE_WFR  = 5'b01000;
  localparam logic [4:0] CE_WQR  = 5'b10000;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam int          DB_CYCLES_DEFAULT = 1000000;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/nexys_starship_debouncer.sv
// Synchronizes a raw push-button, debounces press and release, and emits one
// strobe per confirmed press. Reusable for every station button.
`timescale 1ns/1ps
module nexys_starship_debouncer
  import nexys_starship_combo_entry_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_abort,
  input  logic       i_btn_raw,
  output logic       o_strobe,
  output logic [4:0] o_state
);

  localparam int                CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_btn_meta;
  logic             r_btn_s;
  logic [4:0]       r_state;
  logic [4:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_strobe;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching real hardware.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
    end else begin
      r_btn_meta <= i_btn_raw;
      r_btn_s    <= r_btn_meta;
    end
  end

  // NOTE: defaults at the top of always_comb keep every path assigned, so no
  // latch is inferred.
  always_comb begin
    w_next_state = CE_INI;
    if (i_enable && !i_abort) begin
      case (r_state)
        CE_INI:  w_next_state = r_btn_s ? CE_WQ : CE_INI;
        CE_WQ: begin
          if (!r_btn_s)              w_next_state = CE_INI;
          else if (r_cnt == CNT_LAST) w_next_state = CE_SCEN;
          else                       w_next_state = CE_WQ;
        end
        CE_SCEN: w_next_state = CE_WFR;
        CE_WFR:  w_next_state = r_btn_s ? CE_WFR : CE_WQR;
        CE_WQR: begin
          if (r_btn_s)               w_next_state = CE_WFR;
          else if (r_cnt == CNT_LAST) w_next_state = CE_INI;
          else                       w_next_state = CE_WQR;
        end
        default: w_next_state = CE_INI;
      endcase
    end
  end

  // Counter restarts on every state entry and only runs in the settling states.
  always_comb begin
    w_next_cnt = '0;
    if (w_next_state == r_state && (r_state == CE_WQ || r_state == CE_WQR))
      w_next_cnt = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= CE_INI;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_strobe <= (w_next_state == CE_SCEN);
    end
  end

  assign o_strobe = r_strobe;
  assign o_state  = r_state;

endmodule

// File: rtl/nexys_starship_combo_entry.sv
// Feeds the repair stations: pseudo-random repair code, captured switch combo
// and a debounced one-shot repair strobe from the up-button.
`timescale 1ns/1ps
module nexys_starship_combo_entry
  import nexys_starship_combo_entry_pkg::*;
#(
  parameter int          DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] Sw,
  input  logic       BtnU_raw,
  output logic [3:0] hex_combo,
  output logic [3:0] random_hex,
  output logic       repair_strobe,
  output logic       q_CE_Ini,
  output logic       q_CE_Wq,
  output logic       q_CE_Scen,
  output logic       q_CE_Wfr,
  output logic       q_CE_Wqr
);

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [3:0]  r_sw_meta;
  logic [3:0]  r_sw_s;
  logic [3:0]  r_hex_combo;
  logic [4:0]  w_state;
  logic        w_strobe;
  logic        w_track;

  nexys_starship_debouncer #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_u (
    .i_clk     (Clk),
    .i_reset   (Reset),
    .i_enable  (play_flag),
    .i_abort   (gameover_ctrl),
    .i_btn_raw (BtnU_raw),
    .o_strobe  (w_strobe),
    .o_state   (w_state)
  );

  // A stuck-at-zero LFSR never leaves zero, so reseed it.
  assign w_lfsr_next = (r_lfsr == 16'h0000) ? LFSR_SEED : lfsr_step(r_lfsr);

  always_ff @(posedge Clk) begin
    if (Reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= w_lfsr_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sw_meta <= 4'h0;
      r_sw_s    <= 4'h0;
    end else begin
      r_sw_meta <= Sw;
      r_sw_s    <= r_sw_meta;
    end
  end

  // Tracking in WQ also covers the WQ->SCEN edge, which is the capture.
  assign w_track = (w_state == CE_INI) || (w_state == CE_WQ);

  always_ff @(posedge Clk) begin
    if (Reset)        r_hex_combo <= 4'h0;
    else if (w_track) r_hex_combo <= r_sw_s;
  end

  assign hex_combo     = r_hex_combo;
  assign random_hex    = r_lfsr[3:0];
  assign repair_strobe = w_strobe;
  assign q_CE_Ini      = w_state[0];
  assign q_CE_Wq       = w_state[1];
  assign q_CE_Scen     = w_state[2];
  assign q_CE_Wfr      = w_state[3];
  assign q_CE_Wqr      = w_state[4];

endmodule
